utm_step_engine: RTL and testbench

- Sequential, programmable successor to the fixed combinational Turing-machine transition logic.
- Holds a writable transition table covering 2**STATE_W states x 2**SYM_W symbols.
- Executes machine steps against an external tape memory through read/write req/ack handshakes.
- Tracks head position, current state, step count, halt and fault.
- Sits between the configuration loader and the tape RAM in the universal Turing machine.

---
 rtl/utm_pkg.sv | 40 ++++
 rtl/utm_trans_table.sv | 35 +++
 rtl/utm_step_engine.sv | 177 +++++++++++++++++
 tb/tb_utm_step_engine.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utm_pkg.sv
// Shared definitions for the UTM step engine: transition-entry layout,
// move encodings and the step FSM state type.
package utm_pkg;

  localparam logic MOVE_LEFT  = 1'b0;
  localparam logic MOVE_RIGHT = 1'b1;

  // Entry layout, msb to lsb: {halt, move, next_state, new_sym}
  localparam int unsigned NEW_SYM_LSB = 0;

  function automatic int unsigned utm_entry_w(input int unsigned state_w,
                                              input int unsigned sym_w);
    return 2 + state_w + sym_w;
  endfunction

  function automatic int unsigned utm_next_state_lsb(input int unsigned sym_w);
    return sym_w;
  endfunction

  function automatic int unsigned utm_move_bit(input int unsigned state_w,
                                               input int unsigned sym_w);
    return sym_w + state_w;
  endfunction

  function automatic int unsigned utm_halt_bit(input int unsigned state_w,
                                               input int unsigned sym_w);
    return sym_w + state_w + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_READ   = 3'd2,
    ST_LOOKUP = 3'd3,
    ST_WRITE  = 3'd4,
    ST_MOVE   = 3'd5,
    ST_DONE   = 3'd6
  } utm_state_e;

endpackage

// File: rtl/utm_trans_table.sv
// Transition table register file: async clear to all-zero entries,
// one synchronous write port, one combinational read port.
module utm_trans_table
  import utm_pkg::*;
#(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned SYM_W   = 3
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     we,
  input  logic [STATE_W+SYM_W-1:0]                 waddr,
  input  logic [utm_entry_w(STATE_W, SYM_W)-1:0]   wdata,
  input  logic [STATE_W+SYM_W-1:0]                 raddr,
  output logic [utm_entry_w(STATE_W, SYM_W)-1:0]   rdata
);

  localparam int unsigned ENTRY_W = utm_entry_w(STATE_W, SYM_W);
  localparam int unsigned DEPTH   = 2 ** (STATE_W + SYM_W);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/utm_step_engine.sv
// Programmable Turing-machine step engine: walks a writable transition table
// against an external tape RAM via read/write req/ack handshakes.
module utm_step_engine
  import utm_pkg::*;
#(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned POS_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cfg_we,
  input  logic [STATE_W+SYM_W-1:0]                cfg_addr,
  input  logic [utm_entry_w(STATE_W, SYM_W)-1:0]  cfg_data,
  input  logic                                    start,
  input  logic [POS_W-1:0]                        head_init,
  input  logic                                    step_mode,
  input  logic                                    step_req,
  output logic [POS_W-1:0]                        tape_addr,
  output logic                                    tape_rd_req,
  input  logic                                    tape_rd_ack,
  input  logic [SYM_W-1:0]                        tape_rd_data,
  output logic                                    tape_wr_req,
  output logic [SYM_W-1:0]                        tape_wr_data,
  input  logic                                    tape_wr_ack,
  output logic [STATE_W-1:0]                      state_out,
  output logic [POS_W-1:0]                        head_pos,
  output logic [CNT_W-1:0]                        step_count,
  output logic                                    busy,
  output logic                                    halted,
  output logic                                    fault
);

  localparam int unsigned ENTRY_W  = utm_entry_w(STATE_W, SYM_W);
  localparam int unsigned NS_LSB   = utm_next_state_lsb(SYM_W);
  localparam int unsigned MOVE_BIT = utm_move_bit(STATE_W, SYM_W);
  localparam int unsigned HALT_BIT = utm_halt_bit(STATE_W, SYM_W);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  utm_state_e          fsm_q, fsm_d;
  logic [STATE_W-1:0]  mstate_q;
  logic [POS_W-1:0]    head_q;
  logic [CNT_W-1:0]    count_q;
  logic                fault_q;
  logic [SYM_W-1:0]    sym_q;
  logic [ENTRY_W-1:0]  entry_q;
  logic [ENTRY_W-1:0]  table_rdata;
  logic                table_we;
  logic                entry_halt;
  logic                entry_move;
  logic [STATE_W-1:0]  entry_next;
  logic [SYM_W-1:0]    entry_sym;
  logic                off_tape;

  assign entry_halt = entry_q[HALT_BIT];
  assign entry_move = entry_q[MOVE_BIT];
  assign entry_next = entry_q[NS_LSB +: STATE_W];
  assign entry_sym  = entry_q[NEW_SYM_LSB +: SYM_W];
  assign off_tape   = (entry_move == MOVE_LEFT) ? (head_q == '0) : (head_q == '1);

  // busy is decoded from the FSM, so the same-cycle start+cfg_we write lands
  assign table_we = cfg_we && !busy;

  utm_trans_table #(
    .STATE_W (STATE_W),
    .SYM_W   (SYM_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (table_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr ({mstate_q, sym_q}),
    .rdata (table_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    tape_rd_req = 1'b0;
    tape_wr_req = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!step_mode || step_req) fsm_d = ST_READ;
      end
      ST_READ: begin
        tape_rd_req = 1'b1;
        if (tape_rd_ack) fsm_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        fsm_d = ST_WRITE;
      end
      ST_WRITE: begin
        tape_wr_req = 1'b1;
        if (tape_wr_ack) fsm_d = ST_MOVE;
      end
      ST_MOVE: begin
        fsm_d = (entry_halt || off_tape) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) fsm_d = ST_WAIT;
      end
      default: begin
        busy  = 1'b0;
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstate_q <= '0;
      head_q   <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      sym_q    <= '0;
      entry_q  <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mstate_q <= '0;
            head_q   <= head_init;
            count_q  <= '0;
            fault_q  <= 1'b0;
          end
        end
        ST_READ: begin
          if (tape_rd_ack) sym_q <= tape_rd_data;
        end
        ST_LOOKUP: begin
          entry_q <= table_rdata;
        end
        ST_MOVE: begin
          mstate_q <= entry_next;
          if (count_q != '1) count_q <= count_q + CNT_ONE;
          // Halt wins over the edge check: a halting step never moves the head
          if (!entry_halt) begin
            if (off_tape) begin
              fault_q <= 1'b1;
            end else if (entry_move == MOVE_RIGHT) begin
              head_q <= head_q + POS_ONE;
            end else begin
              head_q <= head_q - POS_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tape_addr    = head_q;
  assign tape_wr_data = entry_sym;
  assign state_out    = mstate_q;
  assign head_pos     = head_q;
  assign step_count   = count_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_utm_step_engine.sv
// Directed bench for utm_step_engine with a behavioural tape RAM whose
// read/write acks can be delayed or forced.
module tb_utm_step_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        start;
  logic [7:0]  head_init;
  logic        step_mode;
  logic        step_req;
  logic [7:0]  tape_addr;
  logic        tape_rd_req;
  logic        tape_rd_ack;
  logic [2:0]  tape_rd_data;
  logic        tape_wr_req;
  logic [2:0]  tape_wr_data;
  logic        tape_wr_ack;
  logic [2:0]  state_out;
  logic [7:0]  head_pos;
  logic [15:0] step_count;
  logic        busy;
  logic        halted;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  utm_step_engine #(
    .STATE_W (3),
    .SYM_W   (3),
    .POS_W   (8),
    .CNT_W   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .head_init    (head_init),
    .step_mode    (step_mode),
    .step_req     (step_req),
    .tape_addr    (tape_addr),
    .tape_rd_req  (tape_rd_req),
    .tape_rd_ack  (tape_rd_ack),
    .tape_rd_data (tape_rd_data),
    .tape_wr_req  (tape_wr_req),
    .tape_wr_data (tape_wr_data),
    .tape_wr_ack  (tape_wr_ack),
    .state_out    (state_out),
    .head_pos     (head_pos),
    .step_count   (step_count),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault)
  );

  // Tape RAM model
  logic [2:0] tape_mem [0:255] = '{default: 3'd0};
  logic [7:0] rd_wait = '0, wr_wait = '0;
  logic [7:0] rd_delay, wr_delay;
  logic       rd_ack_force, wr_ack_force;
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [2:0] poke_data;

  assign tape_rd_ack  = (tape_rd_req && (rd_wait == rd_delay)) || rd_ack_force;
  assign tape_wr_ack  = (tape_wr_req && (wr_wait == wr_delay)) || wr_ack_force;
  assign tape_rd_data = tape_mem[tape_addr];

  always @(posedge clk) begin
    rd_wait <= (tape_rd_req && !tape_rd_ack) ? rd_wait + 8'd1 : 8'd0;
    wr_wait <= (tape_wr_req && !tape_wr_ack) ? wr_wait + 8'd1 : 8'd0;
    if (poke_en) tape_mem[poke_addr] <= poke_data;
    else if (tape_wr_req && tape_wr_ack) tape_mem[tape_addr] <= tape_wr_data;
  end

  // Handshake monitors
  int   rd_req_cycles = 0, wr_req_cycles = 0, overlap_cnt = 0, drop_cnt = 0;
  logic rd_pend = 1'b0, wr_pend = 1'b0;

  always @(negedge clk) begin
    if (tape_rd_req) rd_req_cycles <= rd_req_cycles + 1;
    if (tape_wr_req) wr_req_cycles <= wr_req_cycles + 1;
    if (tape_rd_req && tape_wr_req) overlap_cnt <= overlap_cnt + 1;
    if (rst_n && ((rd_pend && !tape_rd_req) || (wr_pend && !tape_wr_req)))
      drop_cnt <= drop_cnt + 1;
    rd_pend <= rst_n && tape_rd_req && !tape_rd_ack;
    wr_pend <= rst_n && tape_wr_req && !tape_wr_ack;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [2:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick(1);
    poke_en = 1'b0;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic run_start(input logic [7:0] h);
    head_init = h; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit timed_out);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    timed_out = (halted !== 1'b1);
  endtask

  task automatic test_reset;
    bit [4:0] flags;
    rst_n = 1'b0;
    tick(3);
    flags = {busy, halted, fault, tape_rd_req, tape_wr_req};
    vectors++;
    if (flags !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000", flags);
    end
    vectors++;
    if ({step_count, head_pos, state_out} !== 27'd0) begin
      miscompares++; $display("FAIL reset_regs: got cnt=%0d head=%0d st=%0d expected 0", step_count, head_pos, state_out);
    end
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({busy, halted} !== 2'b00) begin
      miscompares++; $display("FAIL reset_release: got busy=%b halted=%b expected 0 0", busy, halted);
    end
  endtask

  task automatic test_incrementer;
    bit to;
    poke(8'd0, 3'd0); poke(8'd1, 3'd1); poke(8'd2, 3'd1);
    cfg_write(6'd1, 8'h00);  // s0,1: write 0, left, s0
    cfg_write(6'd0, 8'h49);  // s0,0: write 1, right, s1
    cfg_write(6'd8, 8'h88);  // s1,0: write 0, halt
    cfg_write(6'd9, 8'h89);  // s1,1: write 1, halt
    run_start(8'd2);
    wait_halt(200, to);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL inc_timeout: got halted=%b expected 1", halted);
    end
    vectors++;
    if ({tape_mem[0], tape_mem[1], tape_mem[2]} !== 9'b001_000_000) begin
      miscompares++; $display("FAIL inc_tape: got %0d%0d%0d expected 100", tape_mem[0], tape_mem[1], tape_mem[2]);
    end
    vectors++;
    if ({halted, fault, busy} !== 3'b100) begin
      miscompares++; $display("FAIL inc_flags: got h=%b f=%b b=%b expected 1 0 0", halted, fault, busy);
    end
    vectors++;
    if (step_count !== 16'd4) begin
      miscompares++; $display("FAIL inc_count: got %0d expected 4", step_count);
    end
    vectors++;
    if ({state_out, head_pos} !== {3'd1, 8'd1}) begin
      miscompares++; $display("FAIL inc_state_head: got st=%0d head=%0d expected 1 1", state_out, head_pos);
    end
  endtask

  task automatic test_left_fault;
    bit to;
    poke(8'd0, 3'd0);
    cfg_write(6'd0, 8'h03);  // s0,0: write 3, left, s0
    run_start(8'd0);
    wait_halt(50, to);
    vectors++;
    if (to !== 1'b0) begin
      miscompares++; $display("FAIL lf_timeout: got halted=%b expected 1", halted);
    end
    vectors++;
    if ({fault, halted, busy} !== 3'b110) begin
      miscompares++; $display("FAIL lf_flags: got f=%b h=%b b=%b expected 1 1 0", fault, halted, busy);
    end
    vectors++;
    if ({head_pos, step_count} !== {8'd0, 16'd1}) begin
      miscompares++; $display("FAIL lf_head_count: got head=%0d cnt=%0d expected 0 1", head_pos, step_count);
    end
    vectors++;
    if (tape_mem[0] !== 3'd3) begin
      miscompares++; $display("FAIL lf_tape: got %0d expected 3", tape_mem[0]);
    end
  endtask

  task automatic test_single_step;
    bit to;
    int rc;
    step_req = 1'b1; tick(1); step_req = 1'b0;
    tick(3);
    vectors++;
    if ({busy, step_count} !== {1'b0, 16'd1}) begin
      miscompares++; $display("FAIL ss_idle_req: got busy=%b cnt=%0d expected 0 1", busy, step_count);
    end
    poke(8'd13, 3'd1);
    cfg_write(6'd0, 8'h42);  // s0,0: write 2, right, s0
    cfg_write(6'd1, 8'h81);  // s0,1: write 1, halt
    step_mode = 1'b1;
    run_start(8'd10);
    rc = rd_req_cycles;
    tick(8);
    vectors++;
    if ((rd_req_cycles - rc) !== 0 || step_count !== 16'd0) begin
      miscompares++; $display("FAIL ss_hold: got rd_cycles=%0d cnt=%0d expected 0 0", rd_req_cycles - rc, step_count);
    end
    for (int k = 1; k <= 3; k++) begin
      step_req = 1'b1; tick(1); step_req = 1'b0;
      tick(2);
      step_req = 1'b1; tick(1); step_req = 1'b0;  // lands mid-step, must be dropped
      tick(8);
      vectors++;
      if (step_count !== 16'(k)) begin
        miscompares++; $display("FAIL ss_count: got %0d expected %0d", step_count, k);
      end
      vectors++;
      if (head_pos !== 8'(10 + k)) begin
        miscompares++; $display("FAIL ss_head: got %0d expected %0d", head_pos, 10 + k);
      end
      rc = rd_req_cycles;
      tick(6);
      vectors++;
      if ((rd_req_cycles - rc) !== 0) begin
        miscompares++; $display("FAIL ss_quiet: got rd_cycles=%0d expected 0", rd_req_cycles - rc);
      end
    end
    step_mode = 1'b0;
    wait_halt(50, to);
    vectors++;
    if ({to, halted, fault, step_count, head_pos} !== {1'b0, 1'b1, 1'b0, 16'd4, 8'd13}) begin
      miscompares++; $display("FAIL ss_finish: got h=%b f=%b cnt=%0d head=%0d expected 1 0 4 13", halted, fault, step_count, head_pos);
    end
  endtask

  task automatic test_backpressure;
    int n, ov, dr, rc, wc;
    ov = overlap_cnt; dr = drop_cnt;
    cfg_write(6'd7, 8'h86);  // s0,7: write 6, halt
    for (int pass = 0; pass < 2; pass++) begin
      poke(8'd50, 3'd7);
      rd_delay = (pass == 0) ? 8'd0 : 8'd4;
      wr_delay = (pass == 0) ? 8'd0 : 8'd2;
      rc = rd_req_cycles; wc = wr_req_cycles;
      run_start(8'd50);
      n = 0;
      while (step_count == 16'd0 && n < 50) begin
        tick(1);
        n++;
      end
      vectors++;
      if (n !== ((pass == 0) ? 5 : 11)) begin
        miscompares++; $display("FAIL bp_latency: got %0d expected %0d", n, (pass == 0) ? 5 : 11);
      end
      vectors++;
      if ((rd_req_cycles - rc) !== ((pass == 0) ? 1 : 5) || (wr_req_cycles - wc) !== ((pass == 0) ? 1 : 3)) begin
        miscompares++; $display("FAIL bp_req_len: got rd=%0d wr=%0d expected %0d %0d", rd_req_cycles - rc, wr_req_cycles - wc, (pass == 0) ? 1 : 5, (pass == 0) ? 1 : 3);
      end
      tick(2);
    end
    vectors++;
    if ({tape_mem[50], head_pos, halted} !== {3'd6, 8'd50, 1'b1}) begin
      miscompares++; $display("FAIL bp_result: got tape=%0d head=%0d h=%b expected 6 50 1", tape_mem[50], head_pos, halted);
    end
    vectors++;
    if ((overlap_cnt - ov) !== 0 || (drop_cnt - dr) !== 0) begin
      miscompares++; $display("FAIL bp_handshake: got overlap=%0d drop=%0d expected 0 0", overlap_cnt - ov, drop_cnt - dr);
    end
    rd_delay = 8'd0; wr_delay = 8'd0;
  endtask

  task automatic test_reset_mid_write;
    bit to;
    int n;
    poke(8'd60, 3'd4);
    cfg_write(6'd4, 8'hC5);  // s0,4: write 5, right, halt
    wr_delay = 8'd30;
    run_start(8'd60);
    n = 0;
    while (tape_wr_req !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    vectors++;
    if (tape_wr_req !== 1'b1) begin
      miscompares++; $display("FAIL rw_reach_write: got wr_req=%b expected 1", tape_wr_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, halted, fault, tape_rd_req, tape_wr_req} !== 5'b0) begin
      miscompares++; $display("FAIL rw_flags: got %b expected 00000", {busy, halted, fault, tape_rd_req, tape_wr_req});
    end
    vectors++;
    if ({step_count, head_pos, tape_addr, tape_wr_data, state_out} !== 38'd0) begin
      miscompares++; $display("FAIL rw_regs: got cnt=%0d head=%0d addr=%0d wd=%0d st=%0d expected 0", step_count, head_pos, tape_addr, tape_wr_data, state_out);
    end
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    wr_delay = 8'd0;
    tick(1);
    wr_ack_force = 1'b1; tick(1); wr_ack_force = 1'b0;
    tick(2);
    vectors++;
    if ({busy, halted, tape_wr_req, step_count} !== 19'd0 || tape_mem[60] !== 3'd4) begin
      miscompares++; $display("FAIL rw_late_ack: got b=%b h=%b wr=%b cnt=%0d tape=%0d expected 0 0 0 0 4", busy, halted, tape_wr_req, step_count, tape_mem[60]);
    end
    poke(8'd0, 3'd4);
    run_start(8'd0);
    wait_halt(50, to);
    vectors++;
    if ({to, tape_mem[0], fault, step_count} !== {1'b0, 3'd0, 1'b1, 16'd1}) begin
      miscompares++; $display("FAIL rw_table_clear: got tape=%0d f=%b cnt=%0d expected 0 1 1", tape_mem[0], fault, step_count);
    end
  endtask

  task automatic test_write_while_busy;
    bit to;
    poke(8'd100, 3'd2);
    cfg_write(6'd2, 8'h83);  // s0,2: write 3, halt
    rd_delay = 8'd6;
    run_start(8'd100);
    tick(1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL wb_busy: got %b expected 1", busy);
    end
    cfg_write(6'd2, 8'h44);  // would be: write 4, right, no halt
    wait_halt(50, to);
    vectors++;
    if ({to, tape_mem[100], fault, step_count, head_pos} !== {1'b0, 3'd3, 1'b0, 16'd1, 8'd100}) begin
      miscompares++; $display("FAIL wb_run: got tape=%0d f=%b cnt=%0d head=%0d expected 3 0 1 100", tape_mem[100], fault, step_count, head_pos);
    end
    rd_delay = 8'd0;
    poke(8'd100, 3'd2);
    run_start(8'd100);
    wait_halt(50, to);
    vectors++;
    if ({to, tape_mem[100], step_count, head_pos} !== {1'b0, 3'd3, 16'd1, 8'd100}) begin
      miscompares++; $display("FAIL wb_readback: got tape=%0d cnt=%0d head=%0d expected 3 1 100", tape_mem[100], step_count, head_pos);
    end
  endtask

  task automatic test_start_with_cfg;
    bit to;
    poke(8'd120, 3'd5);
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_data = 8'h81;  // s0,5: write 1, halt
    head_init = 8'd120; start = 1'b1;
    tick(1);
    cfg_we = 1'b0; start = 1'b0;
    wait_halt(50, to);
    vectors++;
    if ({to, tape_mem[120], halted, fault, step_count} !== {1'b0, 3'd1, 1'b1, 1'b0, 16'd1}) begin
      miscompares++; $display("FAIL sc_run: got tape=%0d h=%b f=%b cnt=%0d expected 1 1 0 1", tape_mem[120], halted, fault, step_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; head_init = '0; step_mode = 1'b0; step_req = 1'b0;
    rd_delay = '0; wr_delay = '0; rd_ack_force = 1'b0; wr_ack_force = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    test_reset;
    test_incrementer;
    test_left_fault;
    test_single_step;
    test_backpressure;
    test_reset_mid_write;
    test_write_while_busy;
    test_start_with_cfg;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
